// File: rtl/mirfak_div_ctrl_pkg.sv
// Shared encodings and constants for the Mirfak divider controller.
// The divider command encoding, controller states and RISC-V special-case constants live here.
package mirfak_div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_CMD_DIV  = 2'b00,
    DIV_CMD_DIVU = 2'b01,
    DIV_CMD_REM  = 2'b10,
    DIV_CMD_REMU = 2'b11
  } div_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_RESP  = 2'b11
  } ctrl_state_e;

  localparam logic [31:0] INT_MIN_C  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES_C = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  cmd;
    logic [31:0] result;
  } cache_entry_t;

endpackage

// File: rtl/mirfak_div_special.sv
// Combinational detector for RISC-V divide-by-zero and signed-overflow cases.
// Divide-by-zero takes priority over overflow.
module mirfak_div_special
  import mirfak_div_ctrl_pkg::*;
(
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [1:0]  i_cmd,
  output logic        o_is_special,
  output logic [31:0] o_result
);

  logic w_div_zero;
  logic w_overflow;
  logic w_is_rem;
  logic w_is_signed;

  assign w_is_rem    = i_cmd[1];
  assign w_is_signed = ~i_cmd[0];
  assign w_div_zero  = (i_op2 == '0);
  assign w_overflow  = w_is_signed && (i_op1 == INT_MIN_C) && (i_op2 == ALL_ONES_C);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    o_is_special = 1'b0;
    o_result     = '0;
    if (w_div_zero) begin
      o_is_special = 1'b1;
      o_result     = w_is_rem ? i_op1 : ALL_ONES_C;
    end else if (w_overflow) begin
      o_is_special = 1'b1;
      o_result     = w_is_rem ? 32'h0 : INT_MIN_C;
    end
  end

endmodule

// File: rtl/mirfak_div_ctrl.sv
// Sequencer between the execute stage and the iterative divider: one-cycle special cases
// and cache hits, enable/ack handshake to the divider, and a clean drain on pipeline kill.
module mirfak_div_ctrl
  import mirfak_div_ctrl_pkg::*;
#(
  parameter bit ENABLE_FASTPATH = 1'b1,
  parameter bit ENABLE_CACHE    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [1:0]  req_cmd,
  input  logic        req_enable,
  input  logic        req_kill,
  output logic [31:0] req_result,
  output logic        req_ack,
  output logic        busy_o,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic [1:0]  div_cmd,
  output logic        div_enable,
  input  logic [31:0] div_result,
  input  logic        div_ack
);

  ctrl_state_e  r_state;
  ctrl_state_e  w_state_next;
  logic [31:0]  r_result;
  logic [31:0]  r_op1;
  logic [31:0]  r_op2;
  logic [1:0]   r_cmd;
  logic         r_cache_valid;
  cache_entry_t r_cache;

  logic        w_special;
  logic [31:0] w_special_result;
  logic        w_fast;
  logic        w_hit;
  logic        w_accept;
  logic        w_div_done;

  mirfak_div_special u_special (
    .i_op1        (req_op1),
    .i_op2        (req_op2),
    .i_cmd        (req_cmd),
    .o_is_special (w_special),
    .o_result     (w_special_result)
  );

  assign w_accept   = (r_state == ST_IDLE) && req_enable && !req_kill;
  assign w_fast     = ENABLE_FASTPATH && w_special;
  assign w_hit      = ENABLE_CACHE && r_cache_valid &&
                      (r_cache.op1 == req_op1) && (r_cache.op2 == req_op2) &&
                      (r_cache.cmd == req_cmd);
  // A kill coinciding with the divider ack discards the result entirely.
  assign w_div_done = (r_state == ST_BUSY) && div_ack && !req_kill;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = (w_fast || w_hit) ? ST_RESP : ST_BUSY;
      ST_BUSY: begin
        if (div_ack)       w_state_next = req_kill ? ST_IDLE : ST_RESP;
        else if (req_kill) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: if (div_ack) w_state_next = ST_IDLE;
      ST_RESP:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_result      <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_cmd         <= '0;
      r_cache_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op1 <= req_op1;
        r_op2 <= req_op2;
        r_cmd <= req_cmd;
        if (w_fast)     r_result <= w_special_result;
        else if (w_hit) r_result <= r_cache.result;
      end
      if (w_div_done) begin
        r_result      <= div_result;
        r_cache_valid <= 1'b1;
      end
    end
  end

  // NOTE: cache payload is not reset; only the valid bit guards it, so the data flops stay plain enables.
  always_ff @(posedge clk_i) begin
    if (w_div_done) begin
      r_cache <= '{op1: r_op1, op2: r_op2, cmd: r_cmd, result: div_result};
    end
  end

  assign req_ack    = (r_state == ST_RESP) && !req_kill;
  assign req_result = r_result;
  assign busy_o     = (r_state != ST_IDLE);
  assign div_op1    = r_op1;
  assign div_op2    = r_op2;
  assign div_cmd    = r_cmd;
  // Dropping enable during the ack cycle guarantees a low cycle before the next start edge.
  assign div_enable = ((r_state == ST_BUSY) || (r_state == ST_DRAIN)) && !div_ack;

endmodule
